keypad_scan: RTL and testbench

//  Scanner for a 4x4 active-low key matrix. It drives one row low at a time, reads the

---
 rtl/keypad_scan.sv | 246 ++++++++++++++++++++++++
 tb/tb_keypad_scan.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/keypad_scan.sv
// 4x4 active-low key matrix scanner: rotates the row drive, samples synchronized
// columns once per row dwell and debounces whole scan frames into key events.
module keypad_scan #(
    parameter int SCAN_CNT  = 50000,
    parameter int DEB_SCANS = 5,
    parameter int CNT_W     = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] col_n,
    output logic [3:0] row_n,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_held
);

    localparam int MW = $clog2(DEB_SCANS + 1);

    localparam logic [1:0] RES_NONE   = 2'd0;
    localparam logic [1:0] RES_SINGLE = 2'd1;
    localparam logic [1:0] RES_MULTI  = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PRESS   = 2'd1,
        ST_HELD    = 2'd2,
        ST_RELEASE = 2'd3
    } state_e;

    // Closed switches in one row sample, saturated at 2 (0 / 1 / many).
    function automatic logic [1:0] hits_in_row(input logic [3:0] cols_n);
        logic [2:0] n;
        n = {2'b00, ~cols_n[0]} + {2'b00, ~cols_n[1]} + {2'b00, ~cols_n[2]} + {2'b00, ~cols_n[3]};
        if (n >= 3'd2) begin
            return RES_MULTI;
        end else begin
            return n[1:0];
        end
    endfunction

    function automatic logic [1:0] low_col(input logic [3:0] cols_n);
        logic [1:0] idx;
        casez (cols_n)
            4'b???0: idx = 2'd0;
            4'b??01: idx = 2'd1;
            4'b?011: idx = 2'd2;
            4'b0111: idx = 2'd3;
            default: idx = 2'd0;
        endcase
        return idx;
    endfunction

    logic [3:0]       col_meta_q, col_sync_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       row_idx_q, row_idx_d;
    logic [3:0]       row_n_q, row_n_d;
    logic [1:0]       acc_hits_q, acc_hits_d;
    logic [3:0]       acc_code_q, acc_code_d;

    state_e           state_q, state_d;
    logic [MW-1:0]    match_q, match_d;
    logic [3:0]       cand_q, cand_d;
    logic [3:0]       key_code_q, key_code_d;
    logic             key_valid_q, key_valid_d;
    logic             key_held_q, key_held_d;

    logic             sample_s;
    logic             frame_end_s;
    logic [1:0]       row_hits_s;
    logic [2:0]       hit_sum_s;
    logic [1:0]       merged_hits_s;
    logic [3:0]       merged_code_s;
    logic [MW-1:0]    match_inc_s;
    logic             accept_s;

    // Two-flop synchronizer on the column lines.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_meta_q <= 4'hF;
            col_sync_q <= 4'hF;
        end else begin
            col_meta_q <= col_n;
            col_sync_q <= col_meta_q;
        end
    end

    // Sample strobe and running merge of this row's hits into the frame accumulator.
    always_comb begin
        sample_s      = (cnt_q == CNT_W'(SCAN_CNT - 1));
        frame_end_s   = sample_s && (row_idx_q == 2'd3);
        row_hits_s    = hits_in_row(col_sync_q);
        hit_sum_s     = {1'b0, acc_hits_q} + {1'b0, row_hits_s};
        merged_hits_s = (hit_sum_s >= 3'd2) ? RES_MULTI : hit_sum_s[1:0];
        if (row_hits_s == RES_SINGLE) begin
            merged_code_s = {row_idx_q, low_col(col_sync_q)};
        end else begin
            merged_code_s = acc_code_q;
        end
    end

    // Dwell counter, row rotation and frame accumulator next state.
    always_comb begin
        cnt_d      = cnt_q + CNT_W'(1);
        row_idx_d  = row_idx_q;
        row_n_d    = row_n_q;
        acc_hits_d = acc_hits_q;
        acc_code_d = acc_code_q;
        if (sample_s) begin
            cnt_d     = {CNT_W{1'b0}};
            row_idx_d = row_idx_q + 2'd1;
            row_n_d   = {row_n_q[2:0], row_n_q[3]};
            if (frame_end_s) begin
                acc_hits_d = RES_NONE;
                acc_code_d = 4'h0;
            end else begin
                acc_hits_d = merged_hits_s;
                acc_code_d = merged_code_s;
            end
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Scan registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q      <= {CNT_W{1'b0}};
            row_idx_q  <= 2'd0;
            row_n_q    <= 4'b1110;
            acc_hits_q <= RES_NONE;
            acc_code_q <= 4'h0;
        end else begin
            cnt_q      <= cnt_d;
            row_idx_q  <= row_idx_d;
            row_n_q    <= row_n_d;
            acc_hits_q <= acc_hits_d;
            acc_code_q <= acc_code_d;
        end
    end

    // Debounce FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            match_q <= {MW{1'b0}};
            cand_q  <= 4'h0;
        end else begin
            state_q <= state_d;
            match_q <= match_d;
            cand_q  <= cand_d;
        end
    end

    // Debounce FSM next state; it only moves on the frame-end sample.
    always_comb begin
        state_d     = state_q;
        match_d     = match_q;
        cand_d      = cand_q;
        accept_s    = 1'b0;
        match_inc_s = match_q + MW'(1);
        if (frame_end_s) begin
            case (state_q)
                ST_IDLE: begin
                    if (merged_hits_s == RES_SINGLE) begin
                        cand_d  = merged_code_s;
                        match_d = MW'(1);
                        state_d = ST_PRESS;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_PRESS: begin
                    if ((merged_hits_s == RES_SINGLE) && (merged_code_s == cand_q)) begin
                        if (match_inc_s == MW'(DEB_SCANS)) begin
                            match_d  = {MW{1'b0}};
                            state_d  = ST_HELD;
                            accept_s = 1'b1;
                        end else begin
                            match_d = match_inc_s;
                        end
                    end else begin
                        match_d = {MW{1'b0}};
                        state_d = ST_IDLE;
                    end
                end
                ST_HELD: begin
                    if (merged_hits_s == RES_NONE) begin
                        match_d = MW'(1);
                        state_d = ST_RELEASE;
                    end else begin
                        state_d = ST_HELD;
                    end
                end
                ST_RELEASE: begin
                    if (merged_hits_s == RES_NONE) begin
                        if (match_inc_s == MW'(DEB_SCANS)) begin
                            match_d = {MW{1'b0}};
                            state_d = ST_IDLE;
                        end else begin
                            match_d = match_inc_s;
                        end
                    end else begin
                        match_d = {MW{1'b0}};
                        state_d = ST_HELD;
                    end
                end
                default: begin
                    match_d = {MW{1'b0}};
                    state_d = ST_IDLE;
                end
            endcase
        end else begin
            state_d = state_q;
        end
    end

    // Output next state: held follows the state being entered so it rises with the pulse.
    always_comb begin
        key_valid_d = accept_s;
        key_held_d  = (state_d == ST_HELD) || (state_d == ST_RELEASE);
        if (accept_s) begin
            key_code_d = cand_q;
        end else begin
            key_code_d = key_code_q;
        end
    end

    // Output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_code_q  <= 4'h0;
            key_valid_q <= 1'b0;
            key_held_q  <= 1'b0;
        end else begin
            key_code_q  <= key_code_d;
            key_valid_q <= key_valid_d;
            key_held_q  <= key_held_d;
        end
    end

    assign row_n     = row_n_q;
    assign key_code  = key_code_q;
    assign key_valid = key_valid_q;
    assign key_held  = key_held_q;

endmodule

// File: tb/tb_keypad_scan.sv
// Bench for keypad_scan: a keypad model drives the columns from a per-frame key mask,
// a frame-level reference model predicts events and a monitor compares DUT outputs.
module tb_keypad_scan;

    localparam int SCAN  = 8;
    localparam int DEB   = 3;
    localparam int FRAME = 4 * SCAN;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  col_n;
    logic [3:0]  row_n;
    logic [3:0]  key_code;
    logic        key_valid;
    logic        key_held;

    logic [15:0] mask = 16'h0000;
    int          total = 0;
    int          bad   = 0;
    int          k;
    logic [3:0]  exp_q[$];
    bit          exp_held = 1'b0;
    logic [3:0]  exp_code = 4'h0;
    bit          fin = 1'b0;
    bit          fin_checked = 1'b0;
    logic [3:0]  mon_e;
    logic [3:0]  mon_row;

    int          m_run  = 0;
    int          m_rel  = 0;
    bit          m_held = 1'b0;
    int          m_code = 0;

    always #5 clk = ~clk;

    keypad_scan #(.SCAN_CNT(SCAN), .DEB_SCANS(DEB), .CNT_W(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .col_n     (col_n),
        .row_n     (row_n),
        .key_code  (key_code),
        .key_valid (key_valid),
        .key_held  (key_held)
    );

    // Keypad matrix: a closed key pulls its column low while its row is driven low.
    always_comb begin
        col_n = 4'hF;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (!row_n[r] && mask[r*4+c]) col_n[c] = 1'b0;
            end
        end
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) k <= 0;
        else        k <= k + 1;
    end

    task automatic chk(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, req);
        end
    endtask

    // Monitor: reset values while in reset, otherwise rotation, pulses, held and code.
    always @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            #1;
            exp_code = 4'h0;
            chk("reset_row_n", row_n, 4'b1110);
            chk("reset_valid", key_valid, 0);
            chk("reset_held", key_held, 0);
            chk("reset_code", key_code, 0);
        end else begin
            mon_row = 4'b1111;
            mon_row[(k / SCAN) % 4] = 1'b0;
            chk("row_n", row_n, mon_row);
            if (key_valid) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_pulse", 1, 0);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("pulse_code", key_code, mon_e);
                    exp_code = mon_e;
                end
            end
            chk("key_held", key_held, exp_held);
            chk("code_stable", key_code, exp_code);
            if (fin && !fin_checked) begin
                chk("pending_pulses", exp_q.size(), 0);
                fin_checked = 1'b1;
            end
        end
    end

    // Reference model: one step per frame from the set of keys closed in it.
    task automatic model_frame(input logic [15:0] m);
        int n;
        int code;
        n = $countones(m);
        code = 0;
        for (int i = 0; i < 16; i++) if (m[i]) code = i;
        if (!m_held) begin
            if (n == 1) begin
                if (m_run == 0) begin
                    m_run = 1;
                    m_code = code;
                end else if (code == m_code) begin
                    m_run++;
                end else begin
                    m_run = 0;
                end
            end else begin
                m_run = 0;
            end
            if (m_run == DEB) begin
                exp_q.push_back(m_code[3:0]);
                m_held = 1'b1;
                m_run = 0;
                m_rel = 0;
            end
        end else begin
            if (n == 0) m_rel++;
            else        m_rel = 0;
            if (m_rel == DEB) begin
                m_held = 1'b0;
                m_rel = 0;
            end
        end
        exp_held = m_held;
    endtask

    task automatic model_reset();
        m_run = 0;
        m_rel = 0;
        m_held = 1'b0;
        exp_q.delete();
        exp_held = 1'b0;
    endtask

    // Called one tick after a frame boundary; holds the mask for n whole frames.
    task automatic frames(input logic [15:0] m, input int n);
        for (int i = 0; i < n; i++) begin
            mask = m;
            repeat (FRAME) @(posedge clk);
            #1;
            model_frame(m);
        end
    endtask

    initial begin
        int a;
        int b;
        logic [15:0] m;
        model_reset();
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        frames(16'h0000, 3);
        frames(16'h0001 << 9, 5);
        frames(16'h0000, 5);
        for (int i = 0; i < 10; i++) begin
            frames(16'h0001, 1);
            frames(16'h0000, 1);
        end
        frames((16'h0001 << 5) | (16'h0001 << 14), 4);
        frames(16'h0001 << 5, 4);
        frames(16'h0000, 4);
        frames(16'h0001 << 9, 4);
        frames((16'h0001 << 9) | (16'h0001 << 5), 2);
        frames(16'h0001 << 5, 2);
        frames(16'h0000, 4);
        frames(16'h0001 << 5, 4);
        frames(16'h0000, 4);

        frames(16'h0001 << 9, 5);
        repeat (13) @(posedge clk);
        #3;
        rst_n = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        frames(16'h0001 << 9, 4);
        frames(16'h0000, 4);

        for (int s = 0; s < 60; s++) begin
            a = $urandom_range(0, 9);
            if (a < 4) begin
                m = 16'h0000;
            end else if (a < 8) begin
                m = 16'h0001 << $urandom_range(0, 15);
            end else begin
                a = $urandom_range(0, 15);
                b = (a + $urandom_range(1, 15)) % 16;
                m = (16'h0001 << a) | (16'h0001 << b);
            end
            frames(m, $urandom_range(1, 5));
        end

        frames(16'h0000, 5);
        fin = 1'b1;
        repeat (2) @(negedge clk);
        #2;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
